// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module      : fetch_sequencer_if
// Description : Instruction-memory, hazard-control and IF/ID bundle for
//               fetch_sequencer. FETCH_PERF_EN adds the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;
`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    modport master (
        output imem_addr,
        input  imem_instr,
        input  stall,
        input  redirect_valid,
        input  redirect_target,
        output if_id_pc,
        output if_id_instr,
        output if_id_valid,
        output halted,
`ifdef FETCH_PERF_EN
        output stall_cycles,
        output flush_count,
`endif
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_instr,
        output stall,
        output redirect_valid,
        output redirect_target,
        input  if_id_pc,
        input  if_id_instr,
        input  if_id_valid,
        input  halted,
`ifdef FETCH_PERF_EN
        input  stall_cycles,
        input  flush_count,
`endif
        input  fetch_count
    );
endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module      : fetch_sequencer
// Description : RV32 instruction-fetch controller: PC, IF/ID register, stall,
//               redirect/flush and out-of-window halt. Optional macro
//               FETCH_PERF_EN adds stall_cycles / flush_count counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_LIMIT = 32'd84,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  wire logic           clk,
    input  wire logic           reset,
    fetch_sequencer_if.master   bus
);

    localparam logic [0:0] c_state_run  = 1'b0;
    localparam logic [0:0] c_state_halt = 1'b1;

    logic [0:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [31:0] r_fetch_count;
    logic [31:0] w_target;

    // Redirect targets are forced onto a word boundary.
    assign w_target = {bus.redirect_target[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_state_run;
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_valid <= 1'b0;
            r_fetch_count <= 32'd0;
        end else if (bus.redirect_valid) begin
            r_pc          <= w_target;
            r_if_id_pc    <= 32'd0;
            r_if_id_instr <= NOP_WORD;
            r_if_id_valid <= 1'b0;
            r_state       <= (w_target > PC_LIMIT) ? c_state_halt : c_state_run;
        end else if (r_state == c_state_run && !bus.stall) begin
            if (r_pc > PC_LIMIT) begin
                r_state       <= c_state_halt;
                r_if_id_instr <= NOP_WORD;
                r_if_id_valid <= 1'b0;
            end else begin
                r_if_id_pc    <= r_pc;
                r_if_id_instr <= bus.imem_instr;
                r_if_id_valid <= 1'b1;
                r_pc          <= r_pc + 32'd4;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (bus.redirect_valid) begin
                r_flush_count <= r_flush_count + 32'd1;
            end else if (r_state == c_state_run && bus.stall) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.flush_count  = r_flush_count;
`endif

    assign bus.imem_addr   = r_pc;
    assign bus.if_id_pc    = r_if_id_pc;
    assign bus.if_id_instr = r_if_id_instr;
    assign bus.if_id_valid = r_if_id_valid;
    assign bus.halted      = (r_state == c_state_halt);
    assign bus.fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed plus randomized bench for fetch_sequencer against a
//               behavioural fetch model. Honors FETCH_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    localparam logic [31:0] c_limit = 32'd84;
    localparam logic [31:0] c_nop   = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] mem [64];
    int          errors;
    int          checks;

    // Behavioural model of the architecturally visible fetch state
    logic [31:0] m_pc, m_if_pc, m_if_instr, m_count, m_stalls, m_flushes;
    logic        m_valid, m_halted, m_if_pc_known;

    fetch_sequencer_if bus ();

    fetch_sequencer #(
        .RESET_PC (32'h0000_0000),
        .PC_LIMIT (c_limit),
        .NOP_WORD (c_nop)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imem_instr = (bus.imem_addr < 32'd256) ? mem[bus.imem_addr[7:2]]
                                                      : (bus.imem_addr ^ 32'hA5A5_0000);

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return (a < 32'd256) ? mem[a[7:2]] : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model by the fetch rules, compare.
    task automatic step(input logic r, input logic s, input logic rv, input logic [31:0] rt);
        logic [31:0] t;
        reset = r; bus.stall = s; bus.redirect_valid = rv; bus.redirect_target = rt;
        t = {rt[31:2], 2'b00};
        if (r) begin
            m_pc = 0; m_if_pc = 0; m_if_instr = c_nop; m_valid = 0; m_halted = 0;
            m_count = 0; m_stalls = 0; m_flushes = 0; m_if_pc_known = 1;
        end else if (rv) begin
            m_pc = t; m_if_pc = 0; m_if_instr = c_nop; m_valid = 0; m_if_pc_known = 1;
            m_halted = (t > c_limit); m_flushes++;
        end else if (m_halted) begin
        end else if (s) begin
            m_stalls++;
        end else if (m_pc > c_limit) begin
            m_halted = 1; m_if_instr = c_nop; m_valid = 0; m_if_pc_known = 0;
        end else begin
            m_if_pc = m_pc; m_if_instr = mem_rd(m_pc); m_valid = 1; m_if_pc_known = 1;
            m_pc += 4; m_count++;
        end
        @(posedge clk);
        #1;
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("if_id_instr", bus.if_id_instr, m_if_instr);
        chk("if_id_valid", {31'd0, bus.if_id_valid}, {31'd0, m_valid});
        chk("halted", {31'd0, bus.halted}, {31'd0, m_halted});
        chk("fetch_count", bus.fetch_count, m_count);
        if (m_if_pc_known) chk("if_id_pc", bus.if_id_pc, m_if_pc);
`ifdef FETCH_PERF_EN
        chk("stall_cycles", bus.stall_cycles, m_stalls);
        chk("flush_count", bus.flush_count, m_flushes);
`endif
    endtask

    initial begin
        errors = 0; checks = 0;
        reset = 1; bus.stall = 0; bus.redirect_valid = 0; bus.redirect_target = 0;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00B08133;

        // Reset and free run
        step(1, 0, 0, 0);
        chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);
        step(0, 0, 0, 0);
        chk("first_word", bus.if_id_instr, 32'h00B08133);
        chk("first_pc", bus.if_id_pc, 32'd0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("count3", bus.fetch_count, 32'd3);
        chk("pc12", bus.imem_addr, 32'd12);

        // Stall at pc=12
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("stall_pc", bus.imem_addr, 32'd12);
        chk("stall_ifpc", bus.if_id_pc, 32'd8);
        step(0, 0, 0, 0);
        chk("post_stall", bus.if_id_instr, mem[3]);

        // Redirect with misaligned target from pc=20
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'd26);
        chk("redir_align", bus.imem_addr, 32'd24);
        chk("redir_nop", bus.if_id_instr, 32'h0000_0013);
        step(0, 0, 0, 0);
        chk("redir_word", bus.if_id_instr, mem[6]);

        // Redirect beats stall
        step(0, 1, 1, 32'd8);
        chk("redir_stall_pc", bus.imem_addr, 32'd8);

        // Run off the end of the window
        for (int i = 0; i < 40 && !m_halted; i++) step(0, 0, 0, 0);
        chk("halt_seen", {31'd0, bus.halted}, 32'd1);
        for (int i = 0; i < 5; i++) step(0, i[0], 0, 0);
        chk("halt_pc", bus.imem_addr, 32'd88);
        step(0, 0, 1, 32'd32);
        chk("restart", {31'd0, bus.halted}, 32'd0);
        step(0, 0, 0, 0);
        chk("restart_word", bus.if_id_instr, mem[8]);
        step(0, 0, 1, 32'd100);
        chk("halt_redirect", {31'd0, bus.halted}, 32'd1);

        // Reset during stall at pc=40
        step(0, 0, 1, 32'd40);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        chk("rst_stall_pc", bus.imem_addr, 32'd0);
        chk("rst_stall_cnt", bus.fetch_count, 32'd0);

        // Performance counter scenario
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 32'd4);
        step(0, 0, 1, 32'd12);
`ifdef FETCH_PERF_EN
        chk("perf_stalls", bus.stall_cycles, 32'd3);
        chk("perf_flushes", bus.flush_count, 32'd2);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic rr, ss, vv;
            logic [31:0] tt;
            rr = ($urandom_range(0, 63) == 0);
            ss = ($urandom_range(0, 4) == 0);
            vv = ($urandom_range(0, 7) == 0);
            tt = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 110);
            step(rr, ss, vv, tt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
